lr35902_oam_dma: RTL and testbench

Bus-initiator block for the LR35902 video subsystem. It owns I/O register 0x46 (DMA) and, on a write, copies 160 bytes from system memory at `{DMA, 8'h00}` into OAM. It drives memory reads as a bus master and OAM writes toward the PPU's sprite RAM. It sits beside the PPU register responder on the same 8-bit I/O register port.

---
 rtl/lr35902_oam_dma.sv | 150 +++++++++++++++
 tb/tb_lr35902_oam_dma.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/lr35902_oam_dma.sv
// rtl/lr35902_oam_dma.sv - LR35902 OAM DMA engine (I/O register 0x46)
//
// Purpose: on a write to I/O register 0x46, copies 160 bytes from system
// memory at {DMA, 8'h00} into OAM, one byte per cycle, acting as bus master.
//
// Build option: define LR35902_OAM_DMA_ECHO_EN to fold source pages
// 0xE0..0xFF onto 0xC0..0xDF (echo RAM mirror).
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   adr, din       I/O register offset and write data
//   write, read    I/O strobes, sampled on posedge clk
//   dout           registered I/O read data (0xFF for foreign offsets)
//   dma_adr        registered memory read address
//   dma_read       registered memory read request
//   dma_din        memory read data, valid the cycle after dma_read
//   oam_adr        registered OAM byte index 0..159
//   oam_dout       OAM write data (combinational copy of dma_din)
//   oam_write      registered OAM write strobe
//   dma_active     high while a transfer is in progress

module lr35902_oam_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  adr,
  input  logic [7:0]  din,
  input  logic        write,
  input  logic        read,
  output logic [7:0]  dout,
  output logic [15:0] dma_adr,
  output logic        dma_read,
  input  logic [7:0]  dma_din,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_write,
  output logic        dma_active
);

  localparam logic [7:0] DMA_REG  = 8'h46;
  localparam logic [7:0] LAST_IDX = 8'd159;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  src_hi_q, src_hi_d;
  logic [7:0]  dmareg_q, dmareg_d;
  logic [7:0]  dout_q, dout_d;
  logic [15:0] dma_adr_q, dma_adr_d;
  logic        dma_read_q, dma_read_d;
  logic [7:0]  oam_adr_q, oam_adr_d;
  logic        oam_write_q, oam_write_d;

  logic       wr_dma;
  logic [7:0] src_fold;

  assign wr_dma = write && (adr == DMA_REG);

`ifdef LR35902_OAM_DMA_ECHO_EN
  // Echo RAM pages mirror work RAM; only the latched source is folded,
  // the readback register keeps the value the CPU wrote.
  assign src_fold = (din[7:5] == 3'b111) ? (din & 8'hDF) : din;
`else
  assign src_fold = din;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 8'h00;
      src_hi_q    <= 8'h00;
      dmareg_q    <= 8'h00;
      dout_q      <= 8'hFF;
      dma_adr_q   <= 16'h0000;
      dma_read_q  <= 1'b0;
      oam_adr_q   <= 8'h00;
      oam_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_hi_q    <= src_hi_d;
      dmareg_q    <= dmareg_d;
      dout_q      <= dout_d;
      dma_adr_q   <= dma_adr_d;
      dma_read_q  <= dma_read_d;
      oam_adr_q   <= oam_adr_d;
      oam_write_q <= oam_write_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    src_hi_d = src_hi_q;
    dmareg_d = dmareg_q;

    if (wr_dma) begin
      // A write always (re)starts, whatever state the engine is in.
      state_d  = S_START;
      src_hi_d = src_fold;
      dmareg_d = din;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_START: state_d = S_XFER;
        S_XFER:  state_d = (idx_q == LAST_IDX) ? S_DRAIN : S_XFER;
        S_DRAIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // idx saturates at 159 so the address never carries into src_hi+1.
    if (state_q == S_START) begin
      idx_d = 8'h00;
    end else if ((state_q == S_XFER) && (idx_q != LAST_IDX)) begin
      idx_d = idx_q + 8'd1;
    end
  end

  // Output logic: registered bus outputs are computed one cycle ahead
  always_comb begin
    dma_read_d  = (state_d == S_XFER);
    dma_adr_d   = dma_read_d ? {src_hi_d, idx_d} : dma_adr_q;
    // Each XFER read lands in OAM the following cycle, unless a restart
    // is taking effect at this edge.
    oam_write_d = (state_q == S_XFER) && !wr_dma;
    oam_adr_d   = (state_q == S_XFER) ? idx_q : oam_adr_q;

    dout_d = dout_q;
    if (read) begin
      dout_d = (adr == DMA_REG) ? dmareg_q : 8'hFF;
    end
  end

  assign dout       = dout_q;
  assign dma_adr    = dma_adr_q;
  assign dma_read   = dma_read_q;
  assign oam_adr    = oam_adr_q;
  assign oam_write  = oam_write_q;
  assign oam_dout   = dma_din;
  assign dma_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_lr35902_oam_dma.sv
// tb/tb_lr35902_oam_dma.sv - scoreboard testbench for lr35902_oam_dma

module tb_lr35902_oam_dma;

  logic        clk = 1'b0;
  logic        reset, write, read;
  logic [7:0]  adr, din, dout, oam_adr, oam_dout;
  logic [7:0]  dma_din = 8'h00;
  logic [15:0] dma_adr;
  logic        dma_read, oam_write, dma_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_rd, first_wr, last_wr, n_wr;
  int t0, n;

  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  echo_hi;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: returns the low address byte one cycle after the read.
  always @(posedge clk) if (dma_read === 1'b1) dma_din <= dma_adr[7:0];

  lr35902_oam_dma dut (
    .clk(clk), .reset(reset), .adr(adr), .din(din), .write(write), .read(read),
    .dout(dout), .dma_adr(dma_adr), .dma_read(dma_read), .dma_din(dma_din),
    .oam_adr(oam_adr), .oam_dout(oam_dout), .oam_write(oam_write),
    .dma_active(dma_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected bus traffic whenever the DUT presents it.
  always @(negedge clk) begin
    if (dma_read === 1'b1) begin
      if (first_rd < 0) first_rd = cyc;
      if (exp_rd.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got dma_adr 0x%0h expected no read", dma_adr);
      end else begin
        chk("dma_adr", {16'h0, dma_adr}, {16'h0, exp_rd.pop_front()});
      end
    end
    if (oam_write === 1'b1) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      n_wr++;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected: got oam 0x%0h=0x%0h expected no write", oam_adr, oam_dout);
      end else begin
        chk("oam_adr_data", {16'h0, oam_adr, oam_dout}, {16'h0, exp_wr.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    adr = a; din = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic io_read_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    adr = a; read = 1'b1;
    tick();
    read = 1'b0;
    chk(name, {24'h0, dout}, {24'h0, exp});
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (dma_active === 1'b1 && cnt < 400) begin
      cnt++;
      tick();
    end
  endtask

  task automatic clr_stats();
    first_rd = -1; first_wr = -1; last_wr = -1; n_wr = 0;
  endtask

  task automatic push_xfer(input logic [7:0] hi, input int nr, input int nw);
    for (int i = 0; i < nr; i++) exp_rd.push_back({hi, 8'(i)});
    for (int i = 0; i < nw; i++) exp_wr.push_back({8'(i), 8'(i)});
  endtask

  task automatic chk_drained(input string name);
    chk(name, exp_rd.size() + exp_wr.size(), 0);
  endtask

  initial begin
    clr_stats();
    reset = 1'b1; write = 1'b0; read = 1'b0; adr = 8'h00; din = 8'h00;
    repeat (3) tick();
    chk("rst_dout", {24'h0, dout}, 32'hFF);
    chk("rst_dma_adr", {16'h0, dma_adr}, 32'h0);
    chk("rst_dma_read", {31'h0, dma_read}, 32'h0);
    chk("rst_oam_adr", {24'h0, oam_adr}, 32'h0);
    chk("rst_oam_write", {31'h0, oam_write}, 32'h0);
    chk("rst_active", {31'h0, dma_active}, 32'h0);
    reset = 1'b0;
    tick();
    io_read_chk("rst_dmareg", 8'h46, 8'h00);

    // Full transfer from 0xC100 with cycle-accurate timing
    clr_stats();
    push_xfer(8'hC1, 160, 160);
    io_write(8'h46, 8'hC1);
    t0 = cyc - 1;
    chk("start_active", {31'h0, dma_active}, 32'h1);
    chk("start_no_read", {31'h0, dma_read}, 32'h0);
    chk("start_no_write", {31'h0, oam_write}, 32'h0);
    wait_idle(n);
    chk("active_cycles", n, 162);
    chk("first_read_cycle", first_rd - t0, 2);
    chk("first_write_cycle", first_wr - t0, 3);
    chk("last_write_cycle", last_wr - t0, 162);
    chk("write_count", n_wr, 160);
    chk_drained("main_drained");

    // Register readback and dout hold
    push_xfer(8'h80, 160, 160);
    io_write(8'h46, 8'h80);
    io_read_chk("rd_46", 8'h46, 8'h80);
    io_read_chk("rd_47", 8'h47, 8'hFF);
    adr = 8'h46;
    tick();
    chk("dout_hold", {24'h0, dout}, 32'hFF);
    wait_idle(n);
    chk_drained("rd_drained");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    io_read_chk("rd_46_after_reset", 8'h46, 8'h00);

    // Read and write of 0x46 in the same cycle returns the old value
    push_xfer(8'h12, 160, 160);
    adr = 8'h46; din = 8'h12; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    chk("rd_wr_same_cycle", {24'h0, dout}, 32'h00);
    wait_idle(n);
    chk_drained("same_drained");
    io_read_chk("rd_46_new", 8'h46, 8'h12);

    // Restart in cycle 50
    clr_stats();
    push_xfer(8'hC0, 49, 48);
    push_xfer(8'hD0, 160, 160);
    io_write(8'h46, 8'hC0);
    repeat (49) tick();
    io_write(8'h46, 8'hD0);
    chk("restart_no_write", {31'h0, oam_write}, 32'h0);
    chk("restart_no_read", {31'h0, dma_read}, 32'h0);
    chk("restart_active", {31'h0, dma_active}, 32'h1);
    wait_idle(n);
    chk("restart_active_cycles", n, 162);
    chk("restart_write_count", n_wr, 208);
    chk_drained("restart_drained");

    // Reset in cycle 80 of a transfer
    push_xfer(8'hC2, 79, 78);
    io_write(8'h46, 8'hC2);
    repeat (79) tick();
    reset = 1'b1;
    tick();
    chk("midrst_dma_read", {31'h0, dma_read}, 32'h0);
    chk("midrst_oam_write", {31'h0, oam_write}, 32'h0);
    chk("midrst_active", {31'h0, dma_active}, 32'h0);
    chk("midrst_dma_adr", {16'h0, dma_adr}, 32'h0);
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_stays_idle", {31'h0, dma_active}, 32'h0);
    chk_drained("midrst_drained");

    // Echo-range source page
`ifdef LR35902_OAM_DMA_ECHO_EN
    echo_hi = 8'hC0;
`else
    echo_hi = 8'hE0;
`endif
    clr_stats();
    push_xfer(echo_hi, 160, 160);
    io_write(8'h46, 8'hE0);
    wait_idle(n);
    chk("echo_active_cycles", n, 162);
    chk_drained("echo_drained");
    io_read_chk("echo_readback", 8'h46, 8'hE0);

    // Write to a neighbouring register must not start a transfer
    io_write(8'h45, 8'hC0);
    for (int i = 0; i < 5; i++) begin
      chk("other_reg_idle", {31'h0, dma_active}, 32'h0);
      chk("other_reg_no_read", {31'h0, dma_read}, 32'h0);
      tick();
    end
    io_read_chk("other_reg_dmareg", 8'h46, 8'hE0);
    chk_drained("final_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
